// File: rtl/disp_framer_if.sv
// disp_framer_if -- valid/ready stream carrying one framed disparity word.
//   m_valid  : word available (driven by the framer)
//   m_ready  : sink accepts the word (driven by the consumer)
//   m_data   : 7-bit disparity or the INVALID marker
//   m_x/m_y  : pixel column (9 bit) / row (8 bit) of the word
//   m_sof    : word is at (0,0)
//   m_eol    : word is the last column of its line
// The framer connects through the master modport, the consumer through slave.
interface disp_framer_if;
  logic       m_valid;
  logic       m_ready;
  logic [6:0] m_data;
  logic [8:0] m_x;
  logic [7:0] m_y;
  logic       m_sof;
  logic       m_eol;

  modport master (
    output m_valid, m_data, m_x, m_y, m_sof, m_eol,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_x, m_y, m_sof, m_eol,
    output m_ready
  );
endinterface

// File: rtl/disp_framer.sv
// disp_framer -- turns the raw disparity stream of the stereo core into framed
// words with pixel coordinates and a valid/ready handshake.
//
// The stereo core output lags its input by LATENCY en strobes, so the first
// LATENCY strobes after reset carry garbage and are discarded (FLUSH). After
// that each strobe (RUN) becomes one word tagged with (x, y); pixels outside the
// trustworthy window (x < VALID_X0 or y < VALID_Y0) carry INVALID instead of the
// disparity. Words are queued in a 4-entry FIFO; if it is full and nothing pops,
// the new word is dropped and the sticky overflow flag is set, but the
// coordinates keep advancing so the raster stays aligned with the core.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (empties FIFO, re-arms the flush)
//   en       : pixel strobe shared with the stereo core
//   disp_in  : disparity from the stereo core (0..79)
//   m        : output stream (disp_framer_if.master)
//   overflow : sticky, set when a word was dropped; cleared only by rst
module disp_framer #(
  parameter int         IMG_W    = 320,
  parameter int         IMG_H    = 240,
  parameter int         LATENCY  = 16,
  parameter int         VALID_X0 = 90,
  parameter int         VALID_Y0 = 10,
  parameter logic [6:0] INVALID  = 7'h7F
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [6:0]           disp_in,
  disp_framer_if.master        m,
  output logic                 overflow
);

  typedef enum logic {S_FLUSH, S_RUN} state_t;

  typedef struct packed {
    logic [6:0] data;
    logic [8:0] x;
    logic [7:0] y;
    logic       sof;
    logic       eol;
  } word_t;

  localparam logic [8:0] X_LAST = 9'(IMG_W - 1);
  localparam logic [7:0] Y_LAST = 8'(IMG_H - 1);
  localparam logic [9:0] LAT    = 10'(LATENCY);
  // Thresholds one bit wider than the coordinates so a window start beyond
  // the coordinate range still compares correctly.
  localparam logic [9:0] VX0    = 10'(VALID_X0);
  localparam logic [8:0] VY0    = 9'(VALID_Y0);
  // With no pipeline to flush the very first strobe after reset is real data.
  localparam state_t     RST_STATE = (LATENCY == 0) ? S_RUN : S_FLUSH;

  state_t     state_q, state_d;
  logic [9:0] flush_cnt_q, flush_cnt_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       overflow_q, overflow_d;
  word_t      mem_q [4];

  logic       push;
  logic       pop;
  logic       full;
  logic       accept;
  logic       valid;
  word_t      in_word;
  word_t      head;

  // Flush counter, run state and raster position.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    push        = 1'b0;
    case (state_q)
      S_FLUSH: begin
        if (en) begin
          flush_cnt_d = flush_cnt_q + 10'd1;
          // The strobe completing the flush is still discarded.
          if (flush_cnt_d == LAT) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (en) begin
          push = 1'b1;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 8'd1;
          end else begin
            x_d = x_q + 9'd1;
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_comb begin
    in_word      = '0;
    in_word.x    = x_q;
    in_word.y    = y_q;
    in_word.sof  = (x_q == '0) && (y_q == '0);
    in_word.eol  = (x_q == X_LAST);
    in_word.data = (({1'b0, x_q} < VX0) || ({1'b0, y_q} < VY0)) ? INVALID : disp_in;
  end

  // FIFO control. A pop frees the head slot in the same cycle, so a push into
  // a full FIFO succeeds when the consumer takes the head at the same edge.
  always_comb begin
    valid      = (count_q != 3'd0);
    pop        = valid && m.m_ready;
    full       = (count_q == 3'd4);
    accept     = push && (!full || pop);
    wr_ptr_d   = wr_ptr_q + 2'(accept);
    rd_ptr_d   = rd_ptr_q + 2'(pop);
    count_d    = count_q + 3'(accept) - 3'(pop);
    overflow_d = overflow_q | (push && full && !pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      flush_cnt_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Word storage needs no reset: the head is only exposed while count_q != 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst && accept && (wr_ptr_q == 2'(i))) begin
        mem_q[i] <= in_word;
      end
    end
  end

  // Outputs read zero while empty, so reset leaves every output at 0.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    m.m_valid = valid;
    m.m_data  = valid ? head.data : '0;
    m.m_x     = valid ? head.x    : '0;
    m.m_y     = valid ? head.y    : '0;
    m.m_sof   = valid ? head.sof  : 1'b0;
    m.m_eol   = valid ? head.eol  : 1'b0;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_disp_framer.sv
// tb_disp_framer -- drives two framers (LATENCY=16 and LATENCY=0) with the
// same stimulus. A queue-level reference model per instance is checked after
// every clock edge; directed tables and sequences cover flush, raster, back-
// pressure, full+pop, mid-frame reset and stall corners.
module tb_disp_framer;

  typedef struct packed {
    logic [6:0] d;
    logic [8:0] x;
    logic [7:0] y;
    logic       sof;
    logic       eol;
  } word_t;

  typedef struct {
    logic       en;
    logic       rdy;
    logic [6:0] d;
    logic       exp_v;
    int         exp_x;
    logic       exp_ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       ready = 1'b0;
  logic [6:0] din = '0;
  logic       ovf0, ovf1;

  always #5 clk = ~clk;

  disp_framer_if if0();
  disp_framer_if if1();
  assign if0.m_ready = ready;
  assign if1.m_ready = ready;

  disp_framer dut0 (
    .clk(clk), .rst(rst), .en(en), .disp_in(din), .m(if0), .overflow(ovf0)
  );
  disp_framer #(.LATENCY(0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .disp_in(din), .m(if1), .overflow(ovf1)
  );

  logic  v  [2];
  word_t hw [2];
  logic  ov [2];
  assign v[0]  = if0.m_valid;
  assign v[1]  = if1.m_valid;
  assign hw[0] = {if0.m_data, if0.m_x, if0.m_y, if0.m_sof, if0.m_eol};
  assign hw[1] = {if1.m_data, if1.m_x, if1.m_y, if1.m_sof, if1.m_eol};
  assign ov[0] = ovf0;
  assign ov[1] = ovf1;

  // Reference model state: a plain list of queued words per instance.
  word_t mq [2][4];
  int    mcnt   [2];
  int    mflush [2];
  int    mx     [2];
  int    my     [2];
  bit    movf   [2];

  int checks = 0;
  int errors = 0;

  function automatic int lat(input int k);
    return (k == 0) ? 16 : 0;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, k, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mcnt[k] = 0; mflush[k] = lat(k); mx[k] = 0; my[k] = 0; movf[k] = 0;
      end else begin
        bit    pop_now;
        bit    have;
        word_t w;
        pop_now = (mcnt[k] > 0) && ready;
        have = 0;
        w = '0;
        if (en) begin
          if (mflush[k] > 0) begin
            mflush[k]--;
          end else begin
            have  = 1;
            w.d   = (mx[k] < 90 || my[k] < 10) ? 7'h7F : din;
            w.x   = 9'(mx[k]);
            w.y   = 8'(my[k]);
            w.sof = (mx[k] == 0 && my[k] == 0);
            w.eol = (mx[k] == 319);
            mx[k]++;
            if (mx[k] == 320) begin
              mx[k] = 0;
              my[k]++;
              if (my[k] == 240) my[k] = 0;
            end
          end
        end
        if (pop_now) begin
          for (int j = 0; j < 3; j++) mq[k][j] = mq[k][j+1];
          mcnt[k]--;
        end
        if (have) begin
          if (mcnt[k] < 4) begin
            mq[k][mcnt[k]] = w;
            mcnt[k]++;
          end else begin
            movf[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk("valid", k, 32'(v[k]), 32'(mcnt[k] > 0));
      if (v[k] && mcnt[k] > 0) chk("head", k, 32'(hw[k]), 32'(mq[k][0]));
      chk("overflow", k, 32'(ov[k]), 32'(movf[k]));
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ready = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  vec_t  tbl [12];
  word_t first_w, last_w;
  bit    got_first, f90, f89;
  logic [6:0] d90, d89;
  int    nwords;

  initial begin
    // Backpressure on the LATENCY=0 instance, starting empty at x=0.
    tbl[0]  = '{1'b1, 1'b0, 7'd1, 1'b1, 0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 7'd2, 1'b1, 0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 7'd3, 1'b1, 0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 7'd4, 1'b1, 0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 7'd5, 1'b1, 0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 7'd0, 1'b1, 1, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 7'd0, 1'b1, 2, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 7'd0, 1'b1, 3, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 7'd0, 1'b0, 0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 7'd6, 1'b1, 5, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 7'd7, 1'b1, 6, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 7'd0, 1'b0, 0, 1'b1};

    // Reset state.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, 32'(v[k]), 32'd0);
      chk("rst_fields", k, 32'(hw[k]), 32'd0);
      chk("rst_ovf", k, 32'(ov[k]), 32'd0);
    end

    // Flush: 20 strobes on LATENCY=16 yield exactly 4 words.
    do_reset();
    ready = 1'b1; nwords = 0; got_first = 0;
    for (int i = 0; i < 24; i++) begin
      en  = (i < 20);
      din = 7'(i);
      if (v[0]) begin
        if (!got_first) begin first_w = hw[0]; got_first = 1; end
        nwords++;
      end
      cyc();
    end
    chk("flush_count", 0, 32'(nwords), 32'd4);
    chk("flush_seen", 0, 32'(got_first), 32'd1);
    chk("flush_first", 0, 32'({first_w.d, first_w.x, first_w.y, first_w.sof}),
        32'({7'h7F, 9'd0, 8'd0, 1'b1}));

    // Backpressure table.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      en = tbl[i].en; ready = tbl[i].rdy; din = tbl[i].d;
      cyc();
      chk("tbl_valid", 1, 32'(v[1]), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) chk("tbl_x", 1, 32'(hw[1].x), 32'(tbl[i].exp_x));
      chk("tbl_ovf", 1, 32'(ov[1]), 32'(tbl[i].exp_ovf));
    end

    // Full FIFO with simultaneous push and pop: nothing dropped.
    do_reset();
    for (int i = 0; i < 4; i++) begin en = 1'b1; ready = 1'b0; din = 7'(i); cyc(); end
    en = 1'b1; ready = 1'b1; cyc();
    chk("fullpop_ovf", 1, 32'(ov[1]), 32'd0);
    en = 1'b0; nwords = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[1]) nwords++;
      cyc();
    end
    chk("fullpop_occ", 1, 32'(nwords), 32'd4);

    // Full raster on LATENCY=0.
    do_reset();
    ready = 1'b1; din = 7'd5; f90 = 0; f89 = 0; d90 = '0; d89 = '0; last_w = '0;
    for (int s = 0; s <= 76800; s++) begin
      en = (s < 76800);
      if (v[1]) begin
        last_w = hw[1];
        if (hw[1].x == 9'd90 && hw[1].y == 8'd10) begin f90 = 1; d90 = hw[1].d; end
        if (hw[1].x == 9'd89 && hw[1].y == 8'd10) begin f89 = 1; d89 = hw[1].d; end
      end
      cyc();
    end
    chk("raster_last", 1, 32'({last_w.x, last_w.y, last_w.eol}), 32'({9'd319, 8'd239, 1'b1}));
    chk("raster_90_10", 1, 32'({f90, d90}), 32'({1'b1, 7'd5}));
    chk("raster_89_10", 1, 32'({f89, d89}), 32'({1'b1, 7'h7F}));
    en = 1'b1; cyc();
    chk("raster_wrap_sof", 1, 32'({v[1], hw[1].sof, hw[1].x, hw[1].y}),
        32'({1'b1, 1'b1, 9'd0, 8'd0}));

    // Mid-frame reset with 3 words queued at (100,1).
    en = 1'b1;
    for (int s = 0; s < 419; s++) cyc();
    en = 1'b0; cyc();
    ready = 1'b0; en = 1'b1;
    for (int s = 0; s < 3; s++) cyc();
    chk("pre_rst_head", 1, 32'({v[1], hw[1].x, hw[1].y}), 32'({1'b1, 9'd100, 8'd1}));
    rst = 1'b1; en = 1'b1; ready = 1'b1; cyc();
    chk("rst_mid_valid", 1, 32'(v[1]), 32'd0);
    chk("rst_mid_valid", 0, 32'(v[0]), 32'd0);
    rst = 1'b0; got_first = 0;
    for (int s = 0; s < 18; s++) begin
      en = (s < 17);
      if (v[0] && !got_first) begin first_w = hw[0]; got_first = 1; end
      cyc();
    end
    chk("reflush_first", 0, 32'({got_first, first_w.x, first_w.y, first_w.sof}),
        32'({1'b1, 9'd0, 8'd0, 1'b1}));

    // Stall: en low for 10 cycles, no words appear, x resumes at 17.
    en = 1'b0;
    for (int s = 0; s < 10; s++) begin
      cyc();
      chk("stall_valid", 1, 32'(v[1]), 32'd0);
    end
    en = 1'b1; cyc();
    chk("stall_resume_x", 1, 32'({v[1], hw[1].x}), 32'({1'b1, 9'd17}));

    // Randomised traffic, long enough to enter the trustworthy window;
    // occasional resets only near the end.
    for (int i = 0; i < 5000; i++) begin
      rst   = (i > 4200) && ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 9) < 8);
      ready = ($urandom_range(0, 9) < 6);
      din   = 7'($urandom_range(0, 79));
      cyc();
    end
    rst = 1'b0; en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
